// File: rtl/udi_spect_dens_mc.sv
// Spectral-density UDI: iterative squarers on the upper DATA_W bits of RS/RT, with
// per-channel thresholds and saturating accumulators. Multiply ops stall M for DATA_W cycles.
module udi_spect_dens_mc #(
  parameter int DATA_W    = 16,
  parameter int NUM_CH    = 8,
  parameter int ACC_W     = 40,
  parameter int TOUDI_W   = 16,
  parameter int FROMUDI_W = 16
) (
  input  logic                 UDI_gclk,
  input  logic                 UDI_greset,
  input  logic                 UDI_gscanenable,
  input  logic [31:0]          UDI_ir_e,
  input  logic                 UDI_irvalid_e,
  input  logic [31:0]          UDI_rs_e,
  input  logic [31:0]          UDI_rt_e,
  input  logic                 UDI_endianb_e,
  input  logic                 UDI_kd_mode_e,
  input  logic                 UDI_start_e,
  input  logic                 UDI_run_m,
  input  logic                 UDI_kill_m,
  input  logic [TOUDI_W-1:0]   UDI_toudi,
  output logic [31:0]          UDI_rd_m,
  output logic [4:0]           UDI_wrreg_e,
  output logic                 UDI_ri_e,
  output logic                 UDI_stall_m,
  output logic                 UDI_present,
  output logic                 UDI_honor_cee,
  output logic [FROMUDI_W-1:0] UDI_fromudi
);

  localparam int          CH_W      = $clog2(NUM_CH);
  localparam int          PW        = 2 * DATA_W;
  localparam logic [63:0] ACC_MAX   = (64'd1 << ACC_W) - 64'd1;
  localparam logic [4:0]  LAST_STEP = 5'(DATA_W - 1);
  localparam logic [5:0]  OP_UDI    = 6'd28;
  localparam logic [5:0]  FN_SUM    = 6'd16;
  localparam logic [5:0]  FN_SUMSH  = 6'd17;
  localparam logic [5:0]  FN_SQ     = 6'd18;
  localparam logic [5:0]  FN_THR_WR = 6'd19;
  localparam logic [5:0]  FN_CMP    = 6'd20;
  localparam logic [5:0]  FN_ACC    = 6'd21;
  localparam logic [5:0]  FN_RDCLR  = 6'd22;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit 32 of the result flags that clamping occurred.
  function automatic logic [32:0] sat32(input logic [63:0] v);
    logic [32:0] r;
    if (v > 64'h0000_0000_FFFF_FFFF) r = {1'b1, 32'hFFFF_FFFF};
    else                             r = {1'b0, v[31:0]};
    return r;
  endfunction

  state_t              state_r;
  logic [5:0]          fn_r;
  logic [CH_W-1:0]     ch_r;
  logic [4:0]          sh_r;
  logic [31:0]         rs_r;
  logic [PW-1:0]       mcand_a_r, mcand_b_r, prod_a_r, prod_b_r;
  logic [DATA_W-1:0]   mult_a_r, mult_b_r;
  logic [4:0]          step_r;
  logic [31:0]         thr_r [NUM_CH];
  logic [ACC_W-1:0]    acc_r [NUM_CH];
  logic                sat_flag_r;
  logic [31:0]         rd_r;

  logic [5:0]          op_s, fn_s;
  logic                fn_ok_s, capture_s, kill_s, zero_stall_s;
  logic [63:0]         sum_s, acc_sum_s, res_wide_s;
  logic [ACC_W-1:0]    acc_new_s;
  logic                acc_sat_s, sat_s;
  logic [32:0]         res_sat_s;
  logic                unused_s;

  // E-stage decode: capture qualification, destination and reserved-instruction flag.
  always_comb begin
    op_s         = UDI_ir_e[31:26];
    fn_s         = UDI_ir_e[5:0];
    fn_ok_s      = (fn_s >= FN_SUM) && (fn_s <= FN_RDCLR);
    capture_s    = UDI_irvalid_e && UDI_start_e && (op_s == OP_UDI) && fn_ok_s && (state_r == ST_IDLE);
    zero_stall_s = (fn_s == FN_THR_WR) || (fn_s == FN_RDCLR);
    kill_s       = UDI_run_m && UDI_kill_m;
    UDI_ri_e     = (op_s == OP_UDI) && (fn_s[5:4] == 2'b01) && !fn_ok_s;
    if (fn_s == FN_THR_WR) UDI_wrreg_e = 5'd0;
    else                   UDI_wrreg_e = UDI_ir_e[15:11];
  end

  // Result and commit values, evaluated from the finished squares while in DONE.
  always_comb begin
    sum_s     = 64'(prod_a_r) + 64'(prod_b_r);
    acc_sum_s = 64'(acc_r[ch_r]) + sum_s;
    if (acc_sum_s > ACC_MAX) begin
      acc_new_s = ACC_MAX[ACC_W-1:0];
      acc_sat_s = 1'b1;
    end else begin
      acc_new_s = acc_sum_s[ACC_W-1:0];
      acc_sat_s = 1'b0;
    end
    case (fn_r)
      FN_SUM:   res_wide_s = sum_s;
      FN_SUMSH: res_wide_s = sum_s >> sh_r;
      FN_SQ:    res_wide_s = 64'(prod_a_r);
      FN_CMP:   res_wide_s = {63'd0, (sum_s > 64'(thr_r[ch_r]))};
      FN_ACC:   res_wide_s = 64'(acc_new_s);
      FN_RDCLR: res_wide_s = 64'(acc_r[ch_r]);
      default:  res_wide_s = 64'd0;
    endcase
    res_sat_s = sat32(res_wide_s);
    sat_s     = res_sat_s[32] | ((fn_r == FN_ACC) & acc_sat_s);
  end

  // Control FSM, shift-add squarers and local state commit.
  always_ff @(posedge UDI_gclk) begin
    if (UDI_greset) begin
      state_r    <= ST_IDLE;
      fn_r       <= 6'd0;
      ch_r       <= {CH_W{1'b0}};
      sh_r       <= 5'd0;
      rs_r       <= 32'd0;
      mcand_a_r  <= {PW{1'b0}};
      mcand_b_r  <= {PW{1'b0}};
      prod_a_r   <= {PW{1'b0}};
      prod_b_r   <= {PW{1'b0}};
      mult_a_r   <= {DATA_W{1'b0}};
      mult_b_r   <= {DATA_W{1'b0}};
      step_r     <= 5'd0;
      sat_flag_r <= 1'b0;
      rd_r       <= 32'd0;
      for (int i = 0; i < NUM_CH; i++) begin
        thr_r[i] <= 32'd0;
        acc_r[i] <= {ACC_W{1'b0}};
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (capture_s) begin
            fn_r      <= fn_s;
            ch_r      <= UDI_ir_e[6 +: CH_W];
            sh_r      <= UDI_ir_e[10:6];
            rs_r      <= UDI_rs_e;
            mcand_a_r <= {{DATA_W{1'b0}}, UDI_rs_e[31 -: DATA_W]};
            mcand_b_r <= {{DATA_W{1'b0}}, UDI_rt_e[31 -: DATA_W]};
            mult_a_r  <= UDI_rs_e[31 -: DATA_W];
            mult_b_r  <= UDI_rt_e[31 -: DATA_W];
            prod_a_r  <= {PW{1'b0}};
            prod_b_r  <= {PW{1'b0}};
            step_r    <= 5'd0;
            state_r   <= zero_stall_s ? ST_DONE : ST_MUL;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_MUL: begin
          if (kill_s) begin
            state_r <= ST_IDLE;
          end else begin
            if (mult_a_r[0]) prod_a_r <= prod_a_r + mcand_a_r;
            if (mult_b_r[0]) prod_b_r <= prod_b_r + mcand_b_r;
            mcand_a_r <= mcand_a_r << 1;
            mcand_b_r <= mcand_b_r << 1;
            mult_a_r  <= mult_a_r >> 1;
            mult_b_r  <= mult_b_r >> 1;
            step_r    <= step_r + 5'd1;
            state_r   <= (step_r == LAST_STEP) ? ST_DONE : ST_MUL;
          end
        end
        ST_DONE: begin
          // A kill here drops the op without touching rd, thresholds, accumulators or the flag.
          if (!kill_s) begin
            rd_r       <= res_sat_s[31:0];
            sat_flag_r <= sat_flag_r | sat_s;
            case (fn_r)
              FN_THR_WR: thr_r[ch_r] <= rs_r;
              FN_ACC:    acc_r[ch_r] <= acc_new_s;
              FN_RDCLR:  acc_r[ch_r] <= {ACC_W{1'b0}};
              default:   ;
            endcase
          end
          state_r <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign UDI_rd_m      = rd_r;
  assign UDI_stall_m   = (state_r == ST_MUL);
  assign UDI_present   = 1'b1;
  assign UDI_honor_cee = 1'b1;
  assign UDI_fromudi   = {{(FROMUDI_W-1){1'b0}}, sat_flag_r};

  assign unused_s = ^{UDI_gscanenable, UDI_endianb_e, UDI_kd_mode_e, UDI_toudi,
                      UDI_ir_e[25:16], UDI_rt_e[31-DATA_W:0]};

endmodule

// File: tb/tb_udi_spect_dens_mc.sv
// Bench for udi_spect_dens_mc: directed cases plus random ops against an arithmetic model
// of the instruction set, with per-cycle checking of stall, result and saturation flag.
module tb_udi_spect_dens_mc;

  localparam int DW = 16;
  localparam int NC = 8;
  localparam int AW = 34;

  logic        clk = 1'b0;
  logic        greset, scan, irvalid, endianb, kd, start, run_m, kill_m;
  logic [31:0] ir_e, rs_e, rt_e;
  logic [15:0] toudi;
  logic [31:0] rd_m;
  logic [4:0]  wrreg_e;
  logic        ri_e, stall_m, present, honor_cee;
  logic [15:0] fromudi;

  always #5 clk = ~clk;

  udi_spect_dens_mc #(.DATA_W(DW), .NUM_CH(NC), .ACC_W(AW), .TOUDI_W(16), .FROMUDI_W(16)) dut (
    .UDI_gclk(clk), .UDI_greset(greset), .UDI_gscanenable(scan), .UDI_ir_e(ir_e),
    .UDI_irvalid_e(irvalid), .UDI_rs_e(rs_e), .UDI_rt_e(rt_e), .UDI_endianb_e(endianb),
    .UDI_kd_mode_e(kd), .UDI_start_e(start), .UDI_run_m(run_m), .UDI_kill_m(kill_m),
    .UDI_toudi(toudi), .UDI_rd_m(rd_m), .UDI_wrreg_e(wrreg_e), .UDI_ri_e(ri_e),
    .UDI_stall_m(stall_m), .UDI_present(present), .UDI_honor_cee(honor_cee),
    .UDI_fromudi(fromudi)
  );

  // Model state
  logic [31:0]     thr_m [NC];
  longint unsigned acc_m [NC];
  bit              flag_m;
  logic [31:0]     exp_rd;
  bit              exp_stall;
  bit              chk_en;
  logic [31:0]     last_res;
  int              total, bad, stall_hi;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      thr_m[i] = 32'd0;
      acc_m[i] = 0;
    end
    flag_m    = 1'b0;
    exp_rd    = 32'd0;
    exp_stall = 1'b0;
  endtask

  task automatic sat32t(input longint unsigned v, output logic [31:0] r);
    if (v > 64'h0000_0000_FFFF_FFFF) begin
      r = 32'hFFFF_FFFF;
      flag_m = 1'b1;
    end else begin
      r = v[31:0];
    end
  endtask

  task automatic model_commit(input int fn, input logic [31:0] rs, input logic [31:0] rt,
                              input logic [4:0] f, output logic [31:0] rd);
    longint unsigned a, b, sum, nv, acc_max;
    int ch, sh;
    a = rs >> (32 - DW);
    b = rt >> (32 - DW);
    sum = a * a + b * b;
    ch = int'(f) % NC;
    sh = int'(f);
    acc_max = (64'd1 << AW) - 1;
    rd = 32'd0;
    case (fn)
      16: sat32t(sum, rd);
      17: sat32t((sh >= 2 * DW + 1) ? 0 : (sum >> sh), rd);
      18: sat32t(a * a, rd);
      19: begin thr_m[ch] = rs; rd = 32'd0; end
      20: rd = (sum > longint'(thr_m[ch])) ? 32'd1 : 32'd0;
      21: begin
        nv = acc_m[ch] + sum;
        if (nv > acc_max) begin
          nv = acc_max;
          flag_m = 1'b1;
        end
        acc_m[ch] = nv;
        sat32t(nv, rd);
      end
      22: begin sat32t(acc_m[ch], rd); acc_m[ch] = 0; end
      default: rd = exp_rd;
    endcase
  endtask

  function automatic logic [31:0] mk_ir(input int fn, input logic [4:0] f, input logic [4:0] rdf);
    logic [5:0] fn6;
    fn6 = fn[5:0];
    return {6'd28, 10'd0, rdf, f, fn6};
  endfunction

  // Per-cycle comparison of the M-stage outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      if (stall_m === 1'b1) stall_hi++;
      check("stall", {63'd0, stall_m}, {63'd0, exp_stall});
      check("rd", {32'd0, rd_m}, {32'd0, exp_rd});
      check("fromudi", {48'd0, fromudi}, {48'd0, 15'd0, flag_m});
    end
  end

  // One instruction: kill_k / inject_c are cycle indexes after capture, -1 for none.
  task automatic do_op(input int fn, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [4:0] f, input int kill_k, input int inject_c);
    logic [31:0] ir, res;
    logic [4:0]  rdf;
    int          len;
    bit          mult, aborted;
    rdf  = 5'($urandom_range(0, 31));
    ir   = mk_ir(fn, f, rdf);
    mult = !(fn == 19 || fn == 22);
    len  = mult ? DW + 1 : 1;
    @(posedge clk); #1;
    ir_e = ir; rs_e = rs; rt_e = rt; irvalid = 1'b1; start = 1'b1;
    #1;
    check("ri_e", {63'd0, ri_e}, 64'd0);
    check("wrreg_e", {59'd0, wrreg_e}, {59'd0, (fn == 19) ? 5'd0 : rdf});
    @(posedge clk);
    for (int c = 0; c <= len; c++) begin
      #1;
      if (c == inject_c) begin
        ir_e = mk_ir(19, 5'd3, 5'd0); rs_e = $urandom; irvalid = 1'b1; start = 1'b1;
      end else begin
        ir_e = 32'd0; irvalid = 1'b0; start = 1'b0;
      end
      kill_m    = (c == kill_k);
      aborted   = (kill_k >= 0) && (c > kill_k);
      exp_stall = mult && (c < DW) && !aborted;
      if (c == len && !aborted) begin
        model_commit(fn, rs, rt, f, res);
        exp_rd   = res;
        last_res = res;
      end
      if (c < len) @(posedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rs, rt;
    int fn, kk, inj, s0;
    total = 0; bad = 0; stall_hi = 0; chk_en = 1'b0;
    greset = 1'b1; scan = 1'b0; irvalid = 1'b0; endianb = 1'b0; kd = 1'b0;
    start = 1'b0; run_m = 1'b1; kill_m = 1'b0; ir_e = 32'd0; rs_e = 32'd0; rt_e = 32'd0;
    toudi = 16'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 greset = 1'b0;
    check("rst_rd", {32'd0, rd_m}, 64'd0);
    check("rst_stall", {63'd0, stall_m}, 64'd0);
    check("rst_fromudi", {48'd0, fromudi}, 64'd0);
    check("present", {62'd0, present, honor_cee}, 64'd3);
    chk_en = 1'b1;

    // 1: SUM (3,4)
    s0 = stall_hi;
    do_op(16, 32'h0003_0000, 32'h0004_0000, 5'd0, -1, -1);
    check("t1_sum", {32'd0, rd_m}, 64'h19);
    check("t1_stall_cycles", 64'(stall_hi - s0), 64'd16);
    // 2: SUMSH sh=2 and SQ
    do_op(17, 32'h0003_0000, 32'h0004_0000, 5'd2, -1, -1);
    check("t2_sumsh", {32'd0, rd_m}, 64'd6);
    do_op(18, 32'h00FF_0000, 32'h1234_0000, 5'd0, -1, -1);
    check("t2_sq", {32'd0, rd_m}, 64'hFE01);
    // 3: threshold compare on both sides of 25, THR_WR zero-stall
    s0 = stall_hi;
    do_op(19, 32'd24, 32'd0, 5'd3, -1, -1);
    check("t3_thr_stall", 64'(stall_hi - s0), 64'd0);
    check("t3_thr_rd", {32'd0, rd_m}, 64'd0);
    do_op(20, 32'h0003_0000, 32'h0004_0000, 5'd3, -1, -1);
    check("t3_cmp24", {32'd0, rd_m}, 64'd1);
    do_op(19, 32'd25, 32'd0, 5'd3, -1, -1);
    do_op(20, 32'h0003_0000, 32'h0004_0000, 5'd3, -1, -1);
    check("t3_cmp25", {32'd0, rd_m}, 64'd0);
    // capture attempt while busy must be ignored
    do_op(16, 32'h0001_0000, 32'h0001_0000, 5'd0, -1, 3);
    do_op(20, 32'h0003_0000, 32'h0004_0000, 5'd3, -1, -1);
    check("t3_busy_nocap", {32'd0, rd_m}, 64'd0);
    // 4: accumulate
    do_op(21, 32'h0003_0000, 32'h0004_0000, 5'd1, -1, -1);
    check("t4_acc1", {32'd0, rd_m}, 64'd25);
    do_op(21, 32'h0003_0000, 32'h0004_0000, 5'd1, -1, -1);
    check("t4_acc2", {32'd0, rd_m}, 64'd50);
    do_op(21, 32'h0003_0000, 32'h0004_0000, 5'd1, -1, -1);
    check("t4_acc3", {32'd0, rd_m}, 64'd75);
    do_op(22, 32'd0, 32'd0, 5'd1, -1, -1);
    check("t4_rdclr", {32'd0, rd_m}, 64'd75);
    do_op(22, 32'd0, 32'd0, 5'd1, -1, -1);
    check("t4_rdclr2", {32'd0, rd_m}, 64'd0);
    do_op(22, 32'd0, 32'd0, 5'd0, -1, -1);
    check("t4_ch0", {32'd0, rd_m}, 64'd0);
    // 6: killed ACC at MUL cycle 5 leaves channel untouched
    do_op(21, 32'h0003_0000, 32'h0004_0000, 5'd2, -1, -1);
    do_op(21, 32'h0003_0000, 32'h0004_0000, 5'd2, 4, -1);
    check("t6_kill_rd", {32'd0, rd_m}, 64'd25);
    do_op(22, 32'd0, 32'd0, 5'd2, -1, -1);
    check("t6_rdclr", {32'd0, rd_m}, 64'd25);
    // invalid fn and wrong major op: no capture
    @(posedge clk); #1;
    ir_e = mk_ir(23, 5'd0, 5'd1); irvalid = 1'b1; start = 1'b1;
    #1 check("ri_fn23", {63'd0, ri_e}, 64'd1);
    @(posedge clk); #1;
    ir_e = {6'd27, 20'd0, 6'd16};
    #1 check("ri_op27", {63'd0, ri_e}, 64'd0);
    @(posedge clk); #1;
    irvalid = 1'b0; start = 1'b0; ir_e = 32'd0;
    // 5: saturating SUM sets the sticky flag
    check("t5_flag_before", {63'd0, fromudi[0]}, 64'd0);
    do_op(16, 32'hFFFF_0000, 32'hFFFF_0000, 5'd0, -1, -1);
    check("t5_sum", {32'd0, rd_m}, 64'hFFFF_FFFF);
    check("t5_flag", {63'd0, fromudi[0]}, 64'd1);
    do_op(16, 32'h0001_0000, 32'h0000_0000, 5'd0, -1, -1);
    check("t5_flag_sticky", {63'd0, fromudi[0]}, 64'd1);
    // accumulator saturation at 2^AW-1, then stays saturated
    for (int i = 0; i < 3; i++) do_op(21, 32'hFFFF_0000, 32'hFFFF_0000, 5'd5, -1, -1);
    do_op(21, 32'h0001_0000, 32'h0000_0000, 5'd5, -1, -1);
    do_op(22, 32'd0, 32'd0, 5'd5, -1, -1);
    check("accsat_rd", {32'd0, rd_m}, 64'hFFFF_FFFF);
    // reset during MUL
    do_op(21, 32'h0003_0000, 32'h0004_0000, 5'd4, -1, -1);
    @(posedge clk); #1;
    ir_e = mk_ir(21, 5'd4, 5'd1); rs_e = 32'h0003_0000; rt_e = 32'h0004_0000;
    irvalid = 1'b1; start = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 4; c++) begin
      #1;
      irvalid = 1'b0; start = 1'b0; ir_e = 32'd0;
      exp_stall = 1'b1;
      if (c == 3) greset = 1'b1;
      @(posedge clk);
    end
    #1 greset = 1'b0;
    model_reset();
    check("rst2_stall", {63'd0, stall_m}, 64'd0);
    check("rst2_rd", {32'd0, rd_m}, 64'd0);
    check("rst2_flag", {63'd0, fromudi[0]}, 64'd0);
    do_op(22, 32'd0, 32'd0, 5'd4, -1, -1);
    check("rst2_acc4", {32'd0, rd_m}, 64'd0);
    do_op(20, 32'h0001_0000, 32'h0000_0000, 5'd3, -1, -1);
    check("rst2_thr3", {32'd0, rd_m}, 64'd1);

    // Random ops
    for (int n = 0; n < 45; n++) begin
      fn = $urandom_range(16, 22);
      case ($urandom_range(0, 2))
        0:       begin rs = $urandom; rt = $urandom; end
        1:       begin rs = {16'hFFFF, 16'($urandom)}; rt = {16'($urandom_range(0, 65535)) | 16'hF000, 16'd0}; end
        default: begin rs = {12'd0, 4'($urandom), 16'($urandom)}; rt = {8'd0, 8'($urandom), 16'd0}; end
      endcase
      kk = -1; inj = -1;
      if ($urandom_range(0, 5) == 0)
        kk = (fn == 19 || fn == 22) ? 0 : $urandom_range(0, DW);
      else if (!(fn == 19 || fn == 22) && $urandom_range(0, 3) == 0)
        inj = $urandom_range(1, DW);
      do_op(fn, rs, rt, 5'($urandom_range(0, 31)), kk, inj);
    end
    for (int ch = 0; ch < NC; ch++) do_op(22, 32'd0, 32'd0, 5'(ch), -1, -1);

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
